usb_rx_packer: RTL

//  Receive-side buffer between a USB function core's byte stream (e.g. usb_serial_top

---
 rtl/usb_pkg.sv | 29 ++
 rtl/usb_byte_fifo.sv | 61 ++++++
 rtl/usb_rx_packer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB peripheral register map, status layout and rx packer states
package usb_pkg;

    localparam logic [31:0] USB_CCR = 32'd0;
    localparam logic [31:0] USB_RDR = 32'd4;
    localparam logic [31:0] USB_TDR = 32'd8;
    localparam logic [31:0] USB_STA = 32'd12;

    localparam int STA_RX_BIT  = 1;
    localparam int STA_CNT_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATHER,
        ST_WR_RDR,
        ST_WR_STA,
        ST_WAIT_ACK
    } rx_state_t;

    // Status word announcing a received RDR word holding cnt valid bytes.
    function automatic logic [31:0] sta_word(input logic [2:0] cnt);
        logic [31:0] r;
        r = '0;
        r[STA_RX_BIT] = 1'b1;
        r[STA_CNT_LSB +: 3] = cnt;
        return r;
    endfunction

endpackage

// File: rtl/usb_byte_fifo.sv
// rtl/usb_byte_fifo.sv - fall-through byte FIFO with occupancy count and synchronous flush
module usb_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/usb_rx_packer.sv
// rtl/usb_rx_packer.sv - packs received USB bytes into 32-bit RDR words, then posts STA
module usb_rx_packer
    import usb_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          rd_ack_i,
    input  logic          flush_i,
    output logic          write_o,
    output logic [31:0]   wraddr_o,
    output logic [31:0]   wdata_o,
    output logic [LW-1:0] level_o,
    output logic          overflow_o
);

    localparam int TW = $clog2(TIMEOUT);

    rx_state_t     state;
    logic [31:0]   word;
    logic [31:0]   word_nx;
    logic [2:0]    cnt;
    logic [TW-1:0] tmr;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign pop = (state == ST_IDLE || state == ST_GATHER) && !fifo_empty && !flush_i;

    always_comb begin
        word_nx = word;
        word_nx[{cnt[1:0], 3'b000} +: 8] = fifo_dout;
    end

    usb_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (flush_i),
        .push  (rx_valid_i),
        .pop   (pop),
        .din   (rx_data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o <= 1'b0;
        end else if (rx_valid_i && fifo_full && !pop) begin
            overflow_o <= 1'b1;
        end
    end

    // Outputs are registered so each WR_* state is exactly its own write cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            word     <= '0;
            cnt      <= '0;
            tmr      <= '0;
            write_o  <= 1'b0;
            wraddr_o <= USB_RDR;
            wdata_o  <= '0;
        end else if (flush_i) begin
            state    <= ST_IDLE;
            word     <= '0;
            cnt      <= '0;
            tmr      <= '0;
            write_o  <= 1'b0;
            wraddr_o <= USB_RDR;
            wdata_o  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_GATHER: begin
                    if (pop) begin
                        word <= word_nx;
                        cnt  <= cnt + 1'b1;
                        tmr  <= '0;
                        if (cnt == 3'd3) begin
                            state    <= ST_WR_RDR;
                            write_o  <= 1'b1;
                            wraddr_o <= USB_RDR;
                            wdata_o  <= word_nx;
                        end else begin
                            state <= ST_GATHER;
                        end
                    end else if (state == ST_GATHER) begin
                        // Partial word: the core went quiet, so hand over what we have.
                        if (tmr == TW'(TIMEOUT - 1)) begin
                            state    <= ST_WR_RDR;
                            write_o  <= 1'b1;
                            wraddr_o <= USB_RDR;
                            wdata_o  <= word;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                end
                ST_WR_RDR: begin
                    state    <= ST_WR_STA;
                    write_o  <= 1'b1;
                    wraddr_o <= USB_STA;
                    wdata_o  <= sta_word(cnt);
                end
                ST_WR_STA: begin
                    state    <= ST_WAIT_ACK;
                    write_o  <= 1'b0;
                    wraddr_o <= USB_RDR;
                    wdata_o  <= '0;
                end
                ST_WAIT_ACK: begin
                    if (rd_ack_i) begin
                        state <= ST_IDLE;
                        word  <= '0;
                        cnt   <= '0;
                        tmr   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
